// File: rtl/dsc_stream_decoder_if.sv
// Result handshake bundle for dsc_stream_decoder: latched count, frame length,
// saturation flag and the valid/ready pair.
interface dsc_stream_decoder_if #(
    parameter int OUT_WIDTH = 18
);
    logic [OUT_WIDTH-1:0] z;
    logic [OUT_WIDTH:0]   len;
    logic                 sat;
    logic                 z_valid;
    logic                 z_ready;

    modport master (output z, len, sat, z_valid, input z_ready);
    modport slave  (input z, len, sat, z_valid, output z_ready);
endinterface

// File: rtl/dsc_stream_decoder.sv
// Framed ones-counter for a DSC bitstream with a valid/ready result handshake.
// Define DSC_DEC_EARLY_STOP_EN to let `stop` truncate a frame.
//
// state | meaning
// IDLE  | waiting for start; stream ignored
// COUNT | frame open, accumulating valid bits (busy=1)
// HOLD  | result presented, waiting for z_ready (z_valid=1)
module dsc_stream_decoder #(
    parameter int SNG_WIDTH  = 6,
    parameter int NUM_INPUTS = 3,
    parameter int OUT_WIDTH  = NUM_INPUTS * SNG_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic sn_in,
    input  logic sn_valid,
    input  logic stop,
    output logic busy,
    dsc_stream_decoder_if.master res
);
    localparam logic [OUT_WIDTH:0] FULL = {1'b1, {OUT_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

    state_t             state;
    logic [OUT_WIDTH:0] ones_cnt;
    logic [OUT_WIDTH:0] bit_cnt;
    logic [OUT_WIDTH:0] ones_nxt;
    logic [OUT_WIDTH:0] bit_nxt;
    logic               early_stop;
    logic               frame_end;

    always_comb begin
        bit_nxt  = bit_cnt + {{OUT_WIDTH{1'b0}}, sn_valid};
        ones_nxt = ones_cnt + {{OUT_WIDTH{1'b0}}, sn_valid & sn_in};
    end

`ifdef DSC_DEC_EARLY_STOP_EN
    assign early_stop = stop;
`else
    logic unused_stop;
    assign unused_stop = stop;
    assign early_stop  = 1'b0;
`endif

    // bit_cnt never exceeds FULL-1 inside COUNT, so equality is enough
    assign frame_end = (sn_valid && (bit_nxt == FULL)) || early_stop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ones_cnt    <= '0;
            bit_cnt     <= '0;
            busy        <= 1'b0;
            res.z       <= '0;
            res.len     <= '0;
            res.sat     <= 1'b0;
            res.z_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ones_cnt <= '0;
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= COUNT;
                    end
                end
                COUNT: begin
                    if (start) begin
                        ones_cnt <= '0;
                        bit_cnt  <= '0;
                    end else begin
                        ones_cnt <= ones_nxt;
                        bit_cnt  <= bit_nxt;
                        if (frame_end) begin
                            // ones can only overflow the result field by exactly one
                            res.z       <= ones_nxt[OUT_WIDTH] ? '1 : ones_nxt[OUT_WIDTH-1:0];
                            res.sat     <= ones_nxt[OUT_WIDTH];
                            res.len     <= bit_nxt;
                            res.z_valid <= 1'b1;
                            busy        <= 1'b0;
                            state       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (res.z_ready) begin
                        res.z_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    res.z_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
